// File: rtl/flo_pkg.sv
// flo_pkg: shared widths and packing-phase encodings for the RX packer
package flo_pkg;
    localparam int SAMPLE_W = 24;
    localparam int WORD_W   = 32;
    localparam int HOLD_W   = 4;
    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;
endpackage

// File: rtl/flo_rx_packer.sv
// flo_rx_packer: packs 24-bit RX FIFO samples little-endian into 32-bit bus words
module flo_rx_packer
    import flo_pkg::*;
#(
    parameter int READ_HOLDOFF = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] fifo_data_i,
    input  logic                fifo_valid_i,
    input  logic                fifo_empty_i,
    output logic                fifo_read_o,
    output logic [WORD_W-1:0]   word_o,
    output logic                word_valid_o,
    input  logic                word_read_i,
    input  logic                flush_i,
    output logic [1:0]          phase_o,
    output logic [15:0]         words_o
);
    phase_t              phase, phase_next;
    logic [SAMPLE_W-1:0] residual;
    logic [HOLD_W-1:0]   holdoff;
    logic                slot_free, accept, flush, emit;
    logic [WORD_W-1:0]   word_next;

    // The output slot can take a new word if it is empty or being drained this cycle.
    // Phase 0 never emits, so it may accept even with a stalled slot.
    assign slot_free   = !word_valid_o || word_read_i;
    assign accept      = !rst && fifo_valid_i && !fifo_empty_i && holdoff == '0 &&
                         (phase == PH0 || slot_free);
    assign flush       = !rst && flush_i && phase != PH0 && slot_free && !accept;
    assign emit        = (accept && phase != PH0) || flush;
    assign fifo_read_o = accept;
    assign phase_o     = phase;

    // Phase register
    always_ff @(posedge clk) begin
        if (rst) phase <= PH0;
        else     phase <= phase_next;
    end

    // Next phase and the word assembled from the residual plus the incoming sample
    always_comb begin
        phase_next = accept ? phase_t'(phase + 2'd1) : flush ? PH0 : phase;
        word_next  = '0;
        case (phase)
            PH1:     word_next = accept ? {fifo_data_i[7:0], residual}
                                        : {8'h0, residual};
            PH2:     word_next = accept ? {fifo_data_i[15:0], residual[23:8]}
                                        : {16'h0, residual[23:8]};
            PH3:     word_next = accept ? {fifo_data_i, residual[23:16]}
                                        : {24'h0, residual[23:16]};
            default: word_next = '0;
        endcase
    end

    // Holdoff masks stale valid/empty/data from the FIFO after each read
    always_ff @(posedge clk) begin
        if (rst)                 holdoff <= '0;
        else if (accept)         holdoff <= HOLD_W'(READ_HOLDOFF);
        else if (holdoff != '0)  holdoff <= holdoff - HOLD_W'(1);
    end

    // Keep the last accepted sample; only its unused high bytes matter next phase
    always_ff @(posedge clk) begin
        if (rst)         residual <= '0;
        else if (accept) residual <= fifo_data_i;
    end

    // Output word register with valid flag and emitted-word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            word_o       <= '0;
            word_valid_o <= 1'b0;
            words_o      <= '0;
        end else if (emit) begin
            word_o       <= word_next;
            word_valid_o <= 1'b1;
            words_o      <= words_o + 16'd1;
        end else if (word_read_i) begin
            word_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_flo_rx_packer.sv
// tb_flo_rx_packer: directed table-driven bench for the RX sample packer
module tb_flo_rx_packer;
    logic        clk = 0;
    logic        rst;
    logic [23:0] fifo_data_i;
    logic        fifo_valid_i;
    logic        fifo_empty_i;
    logic        fifo_read_o;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        word_read_i;
    logic        flush_i;
    logic [1:0]  phase_o;
    logic [15:0] words_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [23:0] sample;
        bit          emit;
        logic [31:0] word;
        logic [1:0]  phase;
    } vec_t;
    vec_t vecs[8];

    flo_rx_packer #(.READ_HOLDOFF(6)) dut (
        .clk(clk), .rst(rst),
        .fifo_data_i(fifo_data_i), .fifo_valid_i(fifo_valid_i), .fifo_empty_i(fifo_empty_i),
        .fifo_read_o(fifo_read_o), .word_o(word_o), .word_valid_o(word_valid_o),
        .word_read_i(word_read_i), .flush_i(flush_i), .phase_o(phase_o), .words_o(words_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1; fifo_valid_i = 0; fifo_empty_i = 0; flush_i = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
    endtask

    // Offer a sample until the DUT reads it; returns at 1 ns past the capturing edge.
    task automatic push(input logic [23:0] d);
        bit ok = 0;
        fifo_data_i = d; fifo_valid_i = 1; fifo_empty_i = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fifo_read_o) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
        end
        fifo_valid_i = 0;
        check("push_accepted", {31'b0, ok}, 32'd1);
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            push(vecs[i].sample);
            check("vec_phase", {30'b0, phase_o}, {30'b0, vecs[i].phase});
            if (vecs[i].emit) begin
                check("vec_valid", {31'b0, word_valid_o}, 32'd1);
                check("vec_word", word_o, vecs[i].word);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, last;
        bit gaps_ok, blocked;
        vecs[0] = '{24'h111111, 0, 32'h0,        2'd1};
        vecs[1] = '{24'h222222, 1, 32'h22111111, 2'd2};
        vecs[2] = '{24'h333333, 1, 32'h33332222, 2'd3};
        vecs[3] = '{24'h444444, 1, 32'h44444433, 2'd0};
        vecs[4] = '{24'h123456, 0, 32'h0,        2'd1};
        vecs[5] = '{24'h789ABC, 1, 32'hBC123456, 2'd2};
        vecs[6] = '{24'hDEF012, 1, 32'hF012789A, 2'd3};
        vecs[7] = '{24'h345678, 1, 32'h345678DE, 2'd0};
        fifo_data_i = 24'h5A5A5A; word_read_i = 0; flush_i = 0;

        // reset state, with a ready FIFO that must not be read during reset
        rst = 1; fifo_valid_i = 1; fifo_empty_i = 0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_word", word_o, 32'h0);
        check("rst_valid", {31'b0, word_valid_o}, 32'd0);
        check("rst_phase", {30'b0, phase_o}, 32'd0);
        check("rst_words", {16'b0, words_o}, 32'd0);
        check("rst_read", {31'b0, fifo_read_o}, 32'd0);
        @(posedge clk); #1;
        rst = 0; fifo_valid_i = 0;

        // basic packing with the bus always reading
        word_read_i = 1;
        run_vec(0, 7);
        check("pack_words", {16'b0, words_o}, 32'd6);
        check("pack_phase", {30'b0, phase_o}, 32'd0);

        // continuous valid: one read every READ_HOLDOFF+1 cycles
        do_reset();
        word_read_i = 1; fifo_valid_i = 1; fifo_empty_i = 0;
        cnt = 0; last = -1; gaps_ok = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fifo_read_o) begin
                if (last >= 0 && i - last != 7) gaps_ok = 0;
                last = i;
                cnt++;
            end
        end
        fifo_valid_i = 0;
        check("holdoff_count", cnt, 32'd5);
        check("holdoff_gap", {31'b0, gaps_ok}, 32'd1);

        // empty FIFO with valid high never reads
        @(posedge clk); #1;
        fifo_valid_i = 1; fifo_empty_i = 1; cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_read_o) cnt++;
        end
        fifo_valid_i = 0; fifo_empty_i = 0;
        check("empty_reads", cnt, 32'd0);

        // backpressure: second word cannot be produced while the first is unread
        do_reset();
        word_read_i = 0;
        push(24'h111111);
        push(24'h222222);
        check("bp_word1", word_o, 32'h22111111);
        check("bp_phase", {30'b0, phase_o}, 32'd2);
        fifo_data_i = 24'h333333; fifo_valid_i = 1; blocked = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (fifo_read_o || word_o !== 32'h22111111 || !word_valid_o) blocked = 0;
        end
        check("bp_blocked", {31'b0, blocked}, 32'd1);
        @(posedge clk); #1;
        word_read_i = 1;
        @(negedge clk);
        check("bp_resume_read", {31'b0, fifo_read_o}, 32'd1);
        @(posedge clk); #1;
        fifo_valid_i = 0; word_read_i = 0;
        check("bp_word2", word_o, 32'h33332222);
        check("bp_valid2", {31'b0, word_valid_o}, 32'd1);
        check("bp_words", {16'b0, words_o}, 32'd2);

        // flush of partial groups at each phase, and flush at phase 0
        do_reset();
        word_read_i = 1;
        push(24'hABCDEF);
        check("fl_phase1", {30'b0, phase_o}, 32'd1);
        flush_i = 1; @(posedge clk); #1; flush_i = 0;
        check("fl1_word", word_o, 32'h00ABCDEF);
        check("fl1_valid", {31'b0, word_valid_o}, 32'd1);
        check("fl1_phase", {30'b0, phase_o}, 32'd0);
        check("fl1_words", {16'b0, words_o}, 32'd1);
        flush_i = 1; repeat (4) @(posedge clk); #1; flush_i = 0;
        check("fl0_words", {16'b0, words_o}, 32'd1);
        check("fl0_valid", {31'b0, word_valid_o}, 32'd0);
        push(24'h123456);
        push(24'h789ABC);
        flush_i = 1; @(posedge clk); #1; flush_i = 0;
        check("fl2_word", word_o, 32'h0000789A);
        check("fl2_words", {16'b0, words_o}, 32'd3);
        push(24'h111111);
        push(24'h222222);
        push(24'h333333);
        flush_i = 1; @(posedge clk); #1; flush_i = 0;
        check("fl3_word", word_o, 32'h00000033);
        check("fl3_phase", {30'b0, phase_o}, 32'd0);
        check("fl3_words", {16'b0, words_o}, 32'd6);

        // reset mid-group with a pending word discards everything
        do_reset();
        word_read_i = 0;
        push(24'h999999);
        push(24'h888888);
        rst = 1; @(posedge clk); #1;
        check("mr_word", word_o, 32'h0);
        check("mr_valid", {31'b0, word_valid_o}, 32'd0);
        check("mr_phase", {30'b0, phase_o}, 32'd0);
        check("mr_words", {16'b0, words_o}, 32'd0);
        rst = 0; word_read_i = 1;
        run_vec(0, 3);
        check("mr_words3", {16'b0, words_o}, 32'd3);
        check("mr_phase_end", {30'b0, phase_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/flo_rx_packer.md
FLO_RX_PACKER -- requirements
Module: flo_rx_packer

Interface
REQ-001 SHALL have parameter READ_HOLDOFF, default 6: cycles after a FIFO read during which no further read is issued; legal range 5..15.
REQ-002 SHALL have port: clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: fifo_data_i  in  24  RX FIFO output sample.
REQ-005 SHALL have port: fifo_valid_i  in  1  RX FIFO data-ready flag.
REQ-006 SHALL have port: fifo_empty_i  in  1  RX FIFO empty flag.
REQ-007 SHALL have port: fifo_read_o  out  1  one-cycle pulse, sample consumed.
REQ-008 SHALL have port: word_o  out  32  packed bus word.
REQ-009 SHALL have port: word_valid_o  out  1  word_o holds an unread word.
REQ-010 SHALL have port: word_read_i  in  1  bus consumed word_o this cycle.
REQ-011 SHALL have port: flush_i  in  1  level request: emit partial word zero-padded.
REQ-012 SHALL have port: phase_o  out  2  current packing phase.
REQ-013 SHALL have port: words_o  out  16  words emitted since reset, wraps at 2^16.

Function
REQ-014 SHALL define slot_free = !word_valid_o || word_read_i.
REQ-015 SHALL accept a sample in cycle t iff fifo_valid_i && !fifo_empty_i && holdoff counter == 0 && (phase == 0 || slot_free).
REQ-016 SHALL drive fifo_read_o combinationally high exactly in accept cycles and capture fifo_data_i in that cycle.
REQ-017 SHALL, after an accept in cycle t, not accept again in cycles t+1..t+READ_HOLDOFF, regardless of fifo_valid_i; this covers upstream stale valid/empty/data.
REQ-018 SHALL pack samples A,B,C,D little-endian into 3 words via a 2-bit phase and residual register.
REQ-019 SHALL, on accept with phase 0, store A as residual, emit no word, and set phase to 1.
REQ-020 SHALL, on accept with phase 1, emit {B[7:0],A[23:0]} and set phase to 2.
REQ-021 SHALL, on accept with phase 2, emit {C[15:0],B[23:8]} and set phase to 3.
REQ-022 SHALL, on accept with phase 3, emit {D[23:0],C[23:16]} and set phase to 0.
REQ-023 SHALL load an emitted word into word_o with word_valid_o=1 on the next edge (1-cycle latency) and increment words_o.
REQ-024 SHALL clear word_valid_o on word_read_i unless a new word loads in the same cycle; word_read_i with word_valid_o=0 is ignored.
REQ-025 SHALL hold word_o stable while word_valid_o=1 and word_read_i=0.
REQ-026 SHALL flush when flush_i && phase != 0 && slot_free && no accept in the same cycle: emit residual zero-padded in the high bits (phase 1 {8'h0,A}, phase 2 {16'h0,B[23:8]}, phase 3 {24'h0,C[23:16]}), set phase to 0, and increment words_o.
REQ-027 SHALL give accept priority over flush; flush with phase 0 SHALL be a no-op.

Reset
REQ-028 SHALL, with rst high, clear word_o, word_valid_o, phase, residual, holdoff counter and words_o to 0, and force fifo_read_o low.
REQ-029 SHALL discard a partial group and any pending word on reset mid-operation; the first post-reset sample SHALL be phase 0.

Structure
REQ-030 SHALL place sample width 24, word width 32 and phase encodings in shared package flo_pkg.
REQ-031 SHALL be a single module with no sub-modules; holdoff counter, phase FSM and output register are inline.

Verification
REQ-032 SHALL cover: samples 0x111111, 0x222222, 0x333333, 0x444444, bus always reading -> words 0x22111111, 0x33332222, 0x44444433, words_o=3, phase_o=0.
REQ-033 SHALL cover: fifo_valid_i=1, fifo_empty_i=0 held, READ_HOLDOFF=6 -> fifo_read_o pulses exactly every 7 cycles.
REQ-034 SHALL cover: fifo_valid_i=1, fifo_empty_i=1 -> fifo_read_o never asserts.
REQ-035 SHALL cover: word_read_i=0 after first word -> phase-2 accept blocked, fifo_read_o low, word_o stable 0x22111111; releasing word_read_i resumes.
REQ-036 SHALL cover: one sample 0xABCDEF then flush_i -> word 0x00ABCDEF, phase_o=0; flush_i at phase 0 emits nothing.
REQ-037 SHALL cover: rst after two samples -> all outputs 0; next four samples pack from phase 0 as in REQ-032.
